// File: rtl/audio_meter_pkg.sv
// audio_meter_pkg
//   Shared definitions for the audio level meter chain. The edge window
//   counter produces COUNT_W-bit counts and the downstream LED bucket decoder
//   consumes them, so both sides take COUNT_W from here.
//   Contents:
//     COUNT_W               width of the edge counters (8)
//     DEFAULT_WINDOW_CYCLES gate window length in clk cycles (10 ms at 48 MHz)
//     win_state_t           gate window FSM states
package audio_meter_pkg;

  localparam int COUNT_W               = 8;
  localparam int DEFAULT_WINDOW_CYCLES = 480000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } win_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//   Two-flop synchronizer for an asynchronous 1-bit input followed by a
//   previous-sample register, producing a one-cycle rising-edge strobe in
//   the clk domain. All flops clear to 0, so an input already high when
//   reset releases shows up as exactly one rising edge.
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     din      in   asynchronous input
//     rise     out  high for one cycle after a synchronized 0->1 transition
module sync_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      // stage 0: first synchronizer flop (may go metastable)
      sync_p0 <= din;
      // stage 1: second synchronizer flop, first safe sample
      sync_p1 <= sync_p0;
      // stage 2: previous safe sample for edge detection
      prev_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/edge_window_counter.sv
// edge_window_counter
//   Counts rising edges of an asynchronous input over back-to-back gate
//   windows of WINDOW_CYCLES clocks and latches a saturated count at the end
//   of each completed window. Dropping enable abandons the running window
//   without touching the latched outputs.
//   Parameters:
//     WINDOW_CYCLES  gate window length in clk cycles (>= 4)
//     COUNT_W        width of the edge counters
//   Ports:
//     clk                 in   system clock
//     reset_n             in   asynchronous active-low reset
//     sig_in              in   asynchronous input (comparator output)
//     enable              in   high = gate windows run, low = idle
//     edge_count_latched  out  count from the last completed window
//     count_valid         out  one-cycle pulse when edge_count_latched updates
//     overflow            out  last completed window saturated
module edge_window_counter #(
  parameter int WINDOW_CYCLES = audio_meter_pkg::DEFAULT_WINDOW_CYCLES,
  parameter int COUNT_W       = audio_meter_pkg::COUNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sig_in,
  input  logic               enable,
  output logic [COUNT_W-1:0] edge_count_latched,
  output logic               count_valid,
  output logic               overflow
);

  import audio_meter_pkg::*;

  localparam int                 WIN_W    = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

  // Adds one edge, holding at the all-ones value instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] cnt,
                                                 input logic               inc);
    if (inc && (cnt != CNT_MAX)) begin
      return cnt + COUNT_W'(1);
    end
    return cnt;
  endfunction

  // True when an edge arrives that sat_add has to drop.
  function automatic logic sat_hit(input logic [COUNT_W-1:0] cnt,
                                   input logic               inc);
    return inc && (cnt == CNT_MAX);
  endfunction

  logic rise;

  sync_edge_detect u_sync_edge_detect (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sig_in),
    .rise    (rise)
  );

  win_state_t         state, state_nxt;
  logic [WIN_W-1:0]   win_cnt, win_cnt_nxt;
  logic [COUNT_W-1:0] run_cnt, run_cnt_nxt;
  logic               sat_flag, sat_flag_nxt;
  logic [COUNT_W-1:0] latch_nxt;
  logic               ovf_nxt;
  logic               vld_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      win_cnt            <= '0;
      run_cnt            <= '0;
      sat_flag           <= 1'b0;
      edge_count_latched <= '0;
      overflow           <= 1'b0;
      count_valid        <= 1'b0;
    end else begin
      state              <= state_nxt;
      win_cnt            <= win_cnt_nxt;
      run_cnt            <= run_cnt_nxt;
      sat_flag           <= sat_flag_nxt;
      edge_count_latched <= latch_nxt;
      overflow           <= ovf_nxt;
      count_valid        <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    win_cnt_nxt  = '0;
    run_cnt_nxt  = '0;
    sat_flag_nxt = 1'b0;
    latch_nxt    = edge_count_latched;
    ovf_nxt      = overflow;
    vld_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          // Disable beats the terminal cycle: the partial window is dropped.
          state_nxt = IDLE;
        end else if (win_cnt == WIN_LAST) begin
          // The closing window owns this cycle's edge; the new window starts
          // at count 0 on the very next cycle.
          latch_nxt = sat_add(run_cnt, rise);
          ovf_nxt   = sat_flag | sat_hit(run_cnt, rise);
          vld_nxt   = 1'b1;
        end else begin
          win_cnt_nxt  = win_cnt + WIN_W'(1);
          run_cnt_nxt  = sat_add(run_cnt, rise);
          sat_flag_nxt = sat_flag | sat_hit(run_cnt, rise);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_edge_window_counter.sv
// tb_edge_window_counter
//   Two instances: dut_a with a 100-cycle window, dut_b with a 2000-cycle
//   window for saturation. A window-level reference model predicts every
//   output on every cycle; directed sequences add fixed expectations.
module tb_edge_window_counter;

  localparam int WA = 100;
  localparam int WB = 2000;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       sig_a   = 1'b0;
  logic       en_a    = 1'b0;
  logic       sig_b   = 1'b0;
  logic       en_b    = 1'b0;
  logic [7:0] cnt_a, cnt_b;
  logic       vld_a, vld_b, ovf_a, ovf_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  edge_window_counter #(.WINDOW_CYCLES(WA), .COUNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_a), .enable(en_a),
    .edge_count_latched(cnt_a), .count_valid(vld_a), .overflow(ovf_a));

  edge_window_counter #(.WINDOW_CYCLES(WB), .COUNT_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_b), .enable(en_b),
    .edge_count_latched(cnt_b), .count_valid(vld_b), .overflow(ovf_b));

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Per instance: the input value seen at each clock edge (newest in bit 0),
  // whether windows are running, the position inside the window and the
  // true (unsaturated) number of edges so far.
  logic [7:0] hist   [2] = '{8'h00, 8'h00};
  logic       run_m  [2] = '{1'b0, 1'b0};
  int         pos_m  [2] = '{0, 0};
  int         edges_m[2] = '{0, 0};
  logic [7:0] cnt_m  [2] = '{8'h00, 8'h00};
  logic       ovf_m  [2] = '{1'b0, 1'b0};
  logic       vld_m  [2] = '{1'b0, 1'b0};

  function automatic logic en_of(input int i);
    return (i == 0) ? en_a : en_b;
  endfunction

  function automatic int win_of(input int i);
    return (i == 0) ? WA : WB;
  endfunction

  // A rising edge is credited two clocks after the input is first seen high
  // following a low sample.
  function automatic int rise_of(input int i);
    return (hist[i][1] && !hist[i][2]) ? 1 : 0;
  endfunction

  function automatic logic [7:0] clip(input int n);
    return (n > 255) ? 8'd255 : n[7:0];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        hist[i] <= '0; run_m[i] <= 1'b0; pos_m[i] <= 0; edges_m[i] <= 0;
        cnt_m[i] <= '0; ovf_m[i] <= 1'b0; vld_m[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        vld_m[i] <= 1'b0;
        hist[i]  <= {hist[i][6:0], (i == 0) ? sig_a : sig_b};
        if (!run_m[i]) begin
          if (en_of(i)) begin
            run_m[i] <= 1'b1; pos_m[i] <= 0; edges_m[i] <= 0;
          end
        end else if (!en_of(i)) begin
          run_m[i] <= 1'b0;
        end else if (pos_m[i] == win_of(i) - 1) begin
          cnt_m[i]   <= clip(edges_m[i] + rise_of(i));
          ovf_m[i]   <= (edges_m[i] + rise_of(i)) > 255;
          vld_m[i]   <= 1'b1;
          pos_m[i]   <= 0;
          edges_m[i] <= 0;
        end else begin
          pos_m[i]   <= pos_m[i] + 1;
          edges_m[i] <= edges_m[i] + rise_of(i);
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    check("model_cnt_a", cnt_a, cnt_m[0]);
    check("model_vld_a", vld_a, vld_m[0]);
    check("model_ovf_a", ovf_a, ovf_m[0]);
    check("model_cnt_b", cnt_b, cnt_m[1]);
    check("model_vld_b", vld_b, vld_m[1]);
    check("model_ovf_b", ovf_b, ovf_m[1]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_sig(input int idx, input logic v);
    if (idx == 0) sig_a = v; else sig_b = v;
  endtask

  task automatic gen_edges(input int idx, input int n, input int p);
    for (int k = 0; k < n; k++) begin
      set_sig(idx, 1'b1);
      repeat (p / 2) @(negedge clk);
      set_sig(idx, 1'b0);
      repeat (p - p / 2) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int idx, input int bound, output int cycles);
    logic seen;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < bound) begin
      @(negedge clk);
      #1;
      cycles++;
      seen = (idx == 0) ? vld_a : vld_b;
    end
    if (!seen) check("wait_valid_timeout", 0, 1);
  endtask

  typedef struct {
    int n_edges;
    int period;
    int exp_cnt;
    int exp_ovf;
  } vec_t;

  vec_t tbl [6];
  int   cyc;
  int   total;
  int   pulses;
  int   hold_a;
  int   hold_b;

  initial begin
    tbl[0] = '{0,  8,  0, 0};
    tbl[1] = '{20, 4,  20, 0};
    tbl[2] = '{1,  10, 1, 0};
    tbl[3] = '{3,  30, 3, 0};
    tbl[4] = '{12, 6,  12, 0};
    tbl[5] = '{10, 8,  10, 0};

    // Reset held with the input toggling: outputs stay 0.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sig_a = ~sig_a;
      #1;
      check("rst_cnt", cnt_a, 0);
      check("rst_vld", vld_a, 0);
      check("rst_ovf", ovf_a, 0);
    end
    sig_a = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic count: 10 edges, period 8, first pulse 101 cycles after enable.
    en_a = 1'b1;
    gen_edges(0, 10, 8);
    wait_valid(0, 200, cyc);
    check("basic_latency", 80 + cyc, 101);
    check("basic_cnt", cnt_a, 10);
    check("basic_ovf", ovf_a, 0);
    @(negedge clk);
    #1;
    check("basic_pulse_width", vld_a, 0);
    check("basic_hold_cnt", cnt_a, 10);

    // Table of whole windows, each started right after a pulse.
    for (int v = 0; v < 6; v++) begin
      gen_edges(0, tbl[v].n_edges, tbl[v].period);
      wait_valid(0, 200, cyc);
      check($sformatf("tbl%0d_cnt", v), cnt_a, tbl[v].exp_cnt);
      check($sformatf("tbl%0d_ovf", v), ovf_a, tbl[v].exp_ovf);
    end

    // Edge landing on the terminal cycle belongs to the closing window.
    repeat (97) @(negedge clk);
    sig_a = 1'b1;
    repeat (2) @(negedge clk);
    sig_a = 1'b0;
    wait_valid(0, 200, cyc);
    check("term_edge_cnt", cnt_a, 1);
    check("term_edge_latency", 99 + cyc, 100);
    wait_valid(0, 200, cyc);
    check("term_edge_next_cnt", cnt_a, 0);

    // Edge landing on the first cycle belongs to the new window.
    repeat (98) @(negedge clk);
    sig_a = 1'b1;
    @(negedge clk);
    wait_valid(0, 200, cyc);
    check("first_edge_prev_cnt", cnt_a, 0);
    repeat (3) @(negedge clk);
    sig_a = 1'b0;
    wait_valid(0, 200, cyc);
    check("first_edge_cnt", cnt_a, 1);

    // Mid-window disable keeps the previous count and emits no pulse.
    gen_edges(0, 7, 8);
    wait_valid(0, 200, cyc);
    check("pre_dis_cnt", cnt_a, 7);
    gen_edges(0, 5, 8);
    repeat (10) @(negedge clk);
    en_a   = 1'b0;
    pulses = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      #1;
      if (vld_a) pulses++;
    end
    check("dis_pulses", pulses, 0);
    check("dis_cnt", cnt_a, 7);
    check("dis_ovf", ovf_a, 0);
    en_a = 1'b1;
    wait_valid(0, 300, cyc);
    check("reen_latency", cyc, 101);
    check("reen_cnt", cnt_a, 0);

    // Reset in the middle of a window after a latch of 7.
    gen_edges(0, 7, 8);
    wait_valid(0, 200, cyc);
    check("pre_rst_cnt", cnt_a, 7);
    gen_edges(0, 3, 8);
    repeat (36) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_cnt", cnt_a, 0);
    check("midrst_vld", vld_a, 0);
    check("midrst_ovf", ovf_a, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_valid(0, 300, cyc);
    check("post_rst_latency", cyc, 101);
    check("post_rst_cnt", cnt_a, 0);
    en_a = 1'b0;

    // Saturation on the 2000-cycle instance, then a normal window.
    en_b = 1'b1;
    for (int j = 0; j < 1996; j++) begin
      sig_b = ((j % 4) < 2);
      @(negedge clk);
    end
    sig_b = 1'b0;
    wait_valid(1, 100, cyc);
    check("sat_cnt", cnt_b, 255);
    check("sat_ovf", ovf_b, 1);
    gen_edges(1, 20, 4);
    wait_valid(1, 2100, cyc);
    check("post_sat_cnt", cnt_b, 20);
    check("post_sat_ovf", ovf_b, 0);

    // Random traffic on both instances against the model.
    en_a   = 1'b1;
    hold_a = 0;
    hold_b = 0;
    for (int k = 0; k < 4500; k++) begin
      @(negedge clk);
      if (hold_a == 0) begin
        sig_a  = ~sig_a;
        hold_a = $urandom_range(0, 5);
      end else hold_a--;
      if (hold_b == 0) begin
        sig_b  = ~sig_b;
        hold_b = $urandom_range(0, 2);
      end else hold_b--;
      if ($urandom_range(0, 399) == 0) en_a = ~en_a;
      if (k == 2500) reset_n = 1'b0;
      if (k == 2502) reset_n = 1'b1;
    end
    en_a = 1'b0;
    en_b = 1'b0;
    repeat (3) @(negedge clk);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
